// File: rtl/cvt_batch_sched.sv
// Batch sequencer: reads fixed(8.8) operands from byte memory, runs the converter, writes float16 results.
// Latency 8 cycles/operand plus converter wait; no backpressure, start is ignored unless IDLE.
module cvt_batch_sched #(
  parameter int ADDR_W  = 8,
  parameter int CNT_W   = 6,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_en,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              cvt_start,
  output logic [15:0]       cvt_operand,
  input  logic              cvt_done,
  input  logic [15:0]       cvt_result
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_LO, S_RD_HI, S_CAPT, S_CVT_GO,
    S_CVT_WAIT, S_WR_LO, S_WR_HI, S_NEXT, S_DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  index;
  logic [TW-1:0]     tmo;
  logic [7:0]        res_hi;

  logic [CNT_W-1:0]  index_nxt;
  logic [ADDR_W-1:0] off;
  logic [ADDR_W-1:0] off_nxt;

  // Byte offset of the current / following operand; wraps with the address space.
  assign index_nxt = index + 1'b1;
  assign off       = ADDR_W'({index, 1'b0});
  assign off_nxt   = ADDR_W'({index_nxt, 1'b0});

  // Outputs are registered, so each is loaded on the transition into the state that owns it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      mem_addr    <= '0;
      mem_wr_en   <= 1'b0;
      mem_wdata   <= '0;
      cvt_start   <= 1'b0;
      cvt_operand <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      cnt_q       <= '0;
      index       <= '0;
      tmo         <= '0;
      res_hi      <= '0;
    end else begin
      done      <= 1'b0;
      mem_wr_en <= 1'b0;
      cvt_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            src_q <= src_base;
            dst_q <= dst_base;
            cnt_q <= count;
            err   <= 1'b0;
            index <= '0;
            if (count == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state    <= S_RD_LO;
              busy     <= 1'b1;
              mem_addr <= src_base;
            end
          end
        end
        S_RD_LO: begin
          mem_addr <= src_q + off + 1'b1;
          state    <= S_RD_HI;
        end
        S_RD_HI: begin
          cvt_operand[7:0] <= mem_rdata;
          state            <= S_CAPT;
        end
        S_CAPT: begin
          cvt_operand[15:8] <= mem_rdata;
          cvt_start         <= 1'b1;
          tmo               <= '0;
          state             <= S_CVT_GO;
        end
        S_CVT_GO: begin
          tmo   <= '0;
          state <= S_CVT_WAIT;
        end
        S_CVT_WAIT: begin
          if (cvt_done) begin
            res_hi    <= cvt_result[15:8];
            mem_wr_en <= 1'b1;
            mem_addr  <= dst_q + off;
            mem_wdata <= cvt_result[7:0];
            state     <= S_WR_LO;
          end else if ((tmo + 1'b1) == TW'(TIMEOUT)) begin
            // Abort: the stalled operand leaves memory untouched.
            err   <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        S_WR_LO: begin
          mem_wr_en <= 1'b1;
          mem_addr  <= dst_q + off + 1'b1;
          mem_wdata <= res_hi;
          state     <= S_WR_HI;
        end
        S_WR_HI: begin
          state <= S_NEXT;
        end
        S_NEXT: begin
          index <= index_nxt;
          if (index_nxt == cnt_q) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            mem_addr <= src_q + off_nxt;
            state    <= S_RD_LO;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cvt_batch_sched.sv
// Directed bench for cvt_batch_sched with byte memory and a table-driven converter stub.
module tb_cvt_batch_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  src_base;
  logic [7:0]  dst_base;
  logic [5:0]  count;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  mem_addr;
  logic        mem_wr_en;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        cvt_start;
  logic [15:0] cvt_operand;
  logic        cvt_done;
  logic [15:0] cvt_result;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [0:255];
  int          wr_cnt = 0;
  int          done_cnt = 0;
  logic        stub_en;
  int          stub_delay;
  int          stub_cnt = 0;
  logic [15:0] op_lat = '0;

  always #5 clk = ~clk;

  cvt_batch_sched #(.ADDR_W(8), .CNT_W(6), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .start(start),
    .src_base(src_base), .dst_base(dst_base), .count(count),
    .busy(busy), .done(done), .err(err),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cvt_start(cvt_start), .cvt_operand(cvt_operand), .cvt_done(cvt_done), .cvt_result(cvt_result)
  );

  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (mem_wr_en) begin
      mem[mem_addr] = mem_wdata;
      wr_cnt = wr_cnt + 1;
    end
    if (done) done_cnt = done_cnt + 1;
  end

  // Hand-computed fixed(8.8) -> float16 pairs used by the directed tests.
  function automatic logic [15:0] fx2h(input logic [15:0] x);
    case (x)
      16'h0100: return 16'h3C00;
      16'h0001: return 16'h1C00;
      16'h8000: return 16'hD800;
      16'hFFFF: return 16'h9C00;
      16'h0200: return 16'h4000;
      16'h0080: return 16'h3800;
      default:  return 16'h7E00;
    endcase
  endfunction

  always @(posedge clk) begin
    cvt_done <= 1'b0;
    if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) begin
        cvt_done   <= 1'b1;
        cvt_result <= fx2h(op_lat);
      end
    end else if (cvt_start && stub_en) begin
      op_lat   <= cvt_operand;
      stub_cnt <= stub_delay;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [7:0] s, input logic [7:0] d, input logic [5:0] n);
    src_base = s; dst_base = d; count = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < maxc) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", {31'd0, done === 1'b1}, 32'd1);
  endtask

  int cyc;
  int wr0;
  int dn0;
  logic [7:0] addr0;

  initial begin
    reset = 1'b0; start = 1'b0; src_base = '0; dst_base = '0; count = '0;
    stub_en = 1'b1; stub_delay = 1;
    for (int i = 0; i < 256; i++) mem[i] = 8'hAA;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
    chk("rst_cvt_start", {31'd0, cvt_start}, 32'd0);
    chk("rst_addr_wdata_op", {mem_addr, mem_wdata, cvt_operand}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Single operand 1.0
    mem[0] = 8'h00; mem[1] = 8'h01;
    wr0 = wr_cnt; dn0 = done_cnt;
    launch(8'h00, 8'h02, 6'd1);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    wait_done(200, cyc);
    chk("t1_latency", cyc, 32'd9);
    chk("t1_err", {31'd0, err}, 32'd0);
    chk("t1_busy_at_done", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("t1_done_pulse", done_cnt - dn0, 32'd1);
    chk("t1_lo", mem[2], 32'h00);
    chk("t1_hi", mem[3], 32'h3C);
    chk("t1_writes", wr_cnt - wr0, 32'd2);

    // Three operands
    mem[8'h10] = 8'h01; mem[8'h11] = 8'h00;
    mem[8'h12] = 8'h00; mem[8'h13] = 8'h80;
    mem[8'h14] = 8'hFF; mem[8'h15] = 8'hFF;
    wr0 = wr_cnt;
    launch(8'h10, 8'h20, 6'd3);
    wait_done(300, cyc);
    chk("t2_latency", cyc, 32'd27);
    chk("t2_r0", {mem[8'h21], mem[8'h20]}, 32'h1C00);
    chk("t2_r1", {mem[8'h23], mem[8'h22]}, 32'hD800);
    chk("t2_r2", {mem[8'h25], mem[8'h24]}, 32'h9C00);
    chk("t2_writes", wr_cnt - wr0, 32'd6);
    @(negedge clk);

    // Empty batch
    wr0 = wr_cnt; addr0 = mem_addr;
    launch(8'h30, 8'h40, 6'd0);
    chk("t3_done_now", {31'd0, done}, 32'd1);
    chk("t3_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("t3_done_drop", {31'd0, done}, 32'd0);
    chk("t3_no_read_addr", mem_addr, addr0);
    chk("t3_writes", wr_cnt - wr0, 32'd0);

    // Converter never answers
    stub_en = 1'b0;
    wr0 = wr_cnt;
    launch(8'h10, 8'h50, 6'd2);
    wait_done(200, cyc);
    chk("t4_latency", cyc, 32'd68);
    chk("t4_err", {31'd0, err}, 32'd1);
    chk("t4_writes", wr_cnt - wr0, 32'd0);
    @(negedge clk);
    chk("t4_err_sticky", {31'd0, err}, 32'd1);
    chk("t4_done_drop", {31'd0, done}, 32'd0);
    stub_en = 1'b1;

    // Source wraps past 0xFF; a second start mid-batch is ignored
    mem[8'hFE] = 8'h00; mem[8'hFF] = 8'h02;
    mem[8'h00] = 8'h80; mem[8'h01] = 8'h00;
    dn0 = done_cnt;
    launch(8'hFE, 8'h40, 6'd2);
    chk("t5_err_cleared", {31'd0, err}, 32'd0);
    repeat (5) @(negedge clk);
    launch(8'h10, 8'h70, 6'd1);
    wait_done(200, cyc);
    repeat (20) @(negedge clk);
    chk("t5_one_done", done_cnt - dn0, 32'd1);
    chk("t5_r0", {mem[8'h41], mem[8'h40]}, 32'h4000);
    chk("t5_r1_wrap", {mem[8'h43], mem[8'h42]}, 32'h3800);
    chk("t5_no_second", {mem[8'h71], mem[8'h70]}, 32'hAAAA);

    // Reset during the second operand's converter wait
    stub_delay = 4;
    mem[8'h50] = 8'h00; mem[8'h51] = 8'h01;
    mem[8'h52] = 8'h00; mem[8'h53] = 8'h02;
    mem[8'h54] = 8'h80; mem[8'h55] = 8'h00;
    mem[8'h56] = 8'h01; mem[8'h57] = 8'h00;
    wr0 = wr_cnt;
    launch(8'h50, 8'h60, 6'd4);
    repeat (17) @(negedge clk);
    chk("t6_in_wait_op", cvt_operand, 32'h0200);
    chk("t6_in_wait_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_rst_flags", {busy, done, err, mem_wr_en, cvt_start}, 32'd0);
    chk("t6_rst_buses", {mem_addr, mem_wdata, cvt_operand}, 32'd0);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("t6_writes", wr_cnt - wr0, 32'd2);
    chk("t6_r0_intact", {mem[8'h61], mem[8'h60]}, 32'h3C00);
    chk("t6_r1_untouched", {mem[8'h63], mem[8'h62]}, 32'hAAAA);

    // Start coinciding with reset is dropped
    src_base = 8'h10; dst_base = 8'h70; count = 6'd1;
    reset = 1'b0; start = 1'b1;
    @(negedge clk);
    reset = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("t7_start_dropped", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
